// File: rtl/btn_debounce_if.sv
// Button bundle between the debouncer and its user: raw levels in,
// debounced levels and edge pulses out.
interface btn_debounce_if #(
    parameter int N_BTN = 4
);
    localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

    logic [N_BTN-1:0] btn;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic             press_valid;
    logic [IDX_W-1:0] press_idx;

    modport master (
        output btn,
        input  btn_level, btn_press, btn_release, press_valid, press_idx
    );

    modport slave (
        input  btn,
        output btn_level, btn_press, btn_release, press_valid, press_idx
    );
endinterface

// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer: two-flop synchronizer, per-channel
// stability counter, registered level plus press/release pulses.
module btn_debounce #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input logic            CLK100MHZ,
    input logic            rst,
    btn_debounce_if.slave  bus
);
    localparam int               IDX_W   = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] s1_q, s2_q;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];
    logic [N_BTN-1:0] level_q, level_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] release_q, release_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        idx_d     = '0;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i]   = s2_q[i];
                    press_d[i]   = s2_q[i];
                    release_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        valid_d = |press_d;
        // Scan downwards so the lowest pressed channel wins.
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (press_d[i]) begin
                idx_d = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            // NOTE: the counter array is reset explicitly; a mid-count reset must discard partial counts.
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= bus.btn;
            s2_q      <= s1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.press_valid = valid_q;
    assign bus.press_idx   = idx_q;
endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce (4 channels, 4-cycle debounce): expected
// outputs are queued as each edge's stimulus is driven and checked after it.
module tb_btn_debounce;
    localparam int N_BTN = 4;
    localparam int DEB   = 4;
    localparam int CNT_W = 3;

    typedef struct packed {
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic       vld;
        logic [1:0] idx;
    } exp_t;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    int   step;
    exp_t exp_q[$];

    btn_debounce_if #(.N_BTN(N_BTN)) bus ();

    btn_debounce #(
        .N_BTN          (N_BTN),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CNT_W)
    ) dut (
        .CLK100MHZ(clk),
        .rst      (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s step %0d: observed %0h expected %0h", tag, step, obs, exp);
        end
    endtask

    // Drive one edge's inputs, queue what that edge must produce, then check it.
    task automatic cyc(input logic r, input logic [3:0] b, input logic [3:0] lvl,
                       input logic [3:0] prs, input logic [3:0] rel, input logic [1:0] idx);
        exp_t e;
        @(negedge clk);
        rst     = r;
        bus.btn = b;
        exp_q.push_back('{lvl: lvl, prs: prs, rel: rel, vld: (prs != 4'b0000), idx: idx});
        @(posedge clk);
        #1;
        step++;
        e = exp_q.pop_front();
        check("btn_level",   32'(bus.btn_level),   32'(e.lvl));
        check("btn_press",   32'(bus.btn_press),   32'(e.prs));
        check("btn_release", 32'(bus.btn_release), 32'(e.rel));
        check("press_valid", 32'(bus.press_valid), 32'(e.vld));
        check("press_idx",   32'(bus.press_idx),   32'(e.idx));
    endtask

    task automatic hold(input logic r, input logic [3:0] b, input logic [3:0] lvl, input int n);
        repeat (n) cyc(r, b, lvl, 4'b0000, 4'b0000, 2'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        step     = 0;
        rst      = 1'b1;
        bus.btn  = '0;

        // Reset state
        hold(1'b1, 4'b0000, 4'b0000, 2);

        // Clean press on channel 0: accepted on the 6th sampling edge
        hold(1'b0, 4'b0001, 4'b0000, 5);
        cyc (1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 2'd0);
        hold(1'b0, 4'b0001, 4'b0001, 3);

        // Release of channel 0
        hold(1'b0, 4'b0000, 4'b0001, 5);
        cyc (1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 2'd0);
        hold(1'b0, 4'b0000, 4'b0000, 2);

        // Glitch on channel 1: three cycles high is too short
        hold(1'b0, 4'b0010, 4'b0000, 3);
        hold(1'b0, 4'b0000, 4'b0000, 8);

        // Bounce on channel 2: 1,0,1,1,0 then held; final rise sampled on edge 6, accepted on edge 11
        hold(1'b0, 4'b0100, 4'b0000, 1);
        hold(1'b0, 4'b0000, 4'b0000, 1);
        hold(1'b0, 4'b0100, 4'b0000, 2);
        hold(1'b0, 4'b0000, 4'b0000, 1);
        hold(1'b0, 4'b0100, 4'b0000, 5);
        cyc (1'b0, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 2'd2);
        hold(1'b0, 4'b0100, 4'b0100, 2);

        // Channels 3 and 1 together while channel 2 stays held
        hold(1'b0, 4'b1110, 4'b0100, 5);
        cyc (1'b0, 4'b1110, 4'b1110, 4'b1010, 4'b0000, 2'd1);
        hold(1'b0, 4'b1110, 4'b1110, 2);

        // Release all three together
        hold(1'b0, 4'b0000, 4'b1110, 5);
        cyc (1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1110, 2'd0);
        hold(1'b0, 4'b0000, 4'b0000, 2);

        // Reset after two counting cycles, then a fresh full count from reset release
        hold(1'b0, 4'b0001, 4'b0000, 4);
        hold(1'b1, 4'b0001, 4'b0000, 1);
        hold(1'b0, 4'b0001, 4'b0000, 5);
        cyc (1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 2'd0);
        hold(1'b0, 4'b0001, 4'b0001, 2);

        // Reset while accepted high clears the level; held button re-presses
        hold(1'b1, 4'b0001, 4'b0000, 1);
        hold(1'b0, 4'b0001, 4'b0000, 5);
        cyc (1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 2'd0);
        hold(1'b0, 4'b0001, 4'b0001, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter N_BTN, default 4: number of button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles needed to accept a new level (10 ms at 100 MHz).
REQ-003 SHALL have parameter CNT_W, default 20: counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-004 SHALL have port CLK100MHZ  input  1: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port btn  input  N_BTN: raw asynchronous push-button levels, 1 = pressed.
REQ-007 SHALL have port btn_level  output  N_BTN: debounced button level, registered.
REQ-008 SHALL have port btn_press  output  N_BTN: one-cycle pulse per channel on each accepted 0->1 transition.
REQ-009 SHALL have port btn_release  output  N_BTN: one-cycle pulse per channel on each accepted 1->0 transition.
REQ-010 SHALL have port press_valid  output  1: high in any cycle where btn_press is non-zero.
REQ-011 SHALL have port press_idx  output  clog2(N_BTN): index of the lowest-numbered bit set in btn_press; 0 when press_valid is 0.

Function
REQ-012 SHALL pass each btn bit through a two-flop synchronizer (s1, s2) before any other use; no logic SHALL be placed between s1 and s2.
REQ-013 SHALL keep one independent counter cnt[i] of CNT_W bits and one accepted level btn_level[i] per channel.
REQ-014 When s2[i] == btn_level[i], cnt[i] SHALL be cleared to 0 on the next edge.
REQ-015 When s2[i] != btn_level[i] and cnt[i] < DEBOUNCE_CYCLES-1, cnt[i] SHALL increment by 1.
REQ-016 When s2[i] != btn_level[i] and cnt[i] == DEBOUNCE_CYCLES-1, btn_level[i] SHALL take s2[i] and cnt[i] SHALL clear to 0 on the same edge.
REQ-017 A raw input step held stable SHALL produce a change in btn_level exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new level.
REQ-018 Any mismatch shorter than DEBOUNCE_CYCLES consecutive s2 cycles SHALL leave btn_level unchanged; a single agreeing cycle SHALL restart the count from 0.
REQ-019 cnt SHALL never wrap; its maximum value is DEBOUNCE_CYCLES-1.
REQ-020 btn_press[i] SHALL be registered high for exactly the one cycle in which btn_level[i] is first seen at 1 after being 0.
REQ-021 btn_release[i] SHALL follow the same rule for 1->0 transitions.
REQ-022 btn_press and btn_release SHALL be 0 in all other cycles.
REQ-023 press_valid and press_idx SHALL be registered in the same cycle as btn_press.
REQ-024 If several channels are accepted on the same edge, btn_press SHALL show all of them, and press_idx SHALL report the lowest index.
REQ-025 Channels SHALL be fully independent; activity on one channel SHALL NOT affect the timing of another.

Reset
REQ-026 While rst is high at a rising edge, the following SHALL be 0 on that edge: s1, s2, cnt, btn_level, btn_press, btn_release, press_valid, press_idx.
REQ-027 rst SHALL take priority over all other updates; asserting it mid-count SHALL discard the partial count.
REQ-028 A button already held high when rst is released SHALL produce btn_press DEBOUNCE_CYCLES+2 edges after the first edge with rst low.

Verification (DEBOUNCE_CYCLES=4, N_BTN=4)
REQ-029 Clean press: rst 0; btn[0] 0->1 held -> btn_level[0]=1 at edge 6, btn_press=4'b0001 for one cycle, press_valid=1, press_idx=0.
REQ-030 Glitch rejection: btn[1] high for 3 cycles then low -> btn_level, btn_press and btn_release stay 0 throughout.
REQ-031 Bounce: btn[2] toggles 1,0,1,1,0 then held 1 -> btn_level[2] rises exactly 6 edges after the final 0->1 is sampled, with one btn_press pulse only.
REQ-032 Simultaneous press: btn[3] and btn[1] rise on the same cycle -> btn_press=4'b1010 for one cycle, press_idx=1.
REQ-033 Release: after an accepted press, btn[0] 1->0 held -> btn_release[0] pulses once at edge 6, and btn_level[0] returns to 0.
REQ-034 Reset mid-count: btn[0] high, rst pulsed after 2 counting cycles -> all outputs 0, then btn_press[0] fires 6 edges after rst falls.
